// File: rtl/fft_frame_controller_if.sv
// Sample stream handshake between an upstream
// source and the FFT frame controller.
interface fft_frame_controller_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_real;
    logic [WIDTH-1:0] in_imag;

    modport master (
        output in_valid,
        output in_real,
        output in_imag,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_real,
        input  in_imag,
        output in_ready
    );
endinterface

// File: rtl/fft_frame_controller.sv
// Frame sequencer for a radix-4 SDF FFT pipeline:
// gates N-sample frames in, drains with dummy frames, tags outputs.
module fft_frame_controller #(
    parameter int WIDTH        = 32,
    parameter int N            = 16,
    parameter int LOG4N        = 2,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    fft_frame_controller_if.slave src,
    input  logic                 flush,
    output logic                 pipe_en,
    output logic [WIDTH-1:0]     pipe_real,
    output logic [WIDTH-1:0]     pipe_imag,
    input  logic                 pipe_out_en,
    input  logic [WIDTH-1:0]     pipe_out_real,
    input  logic [WIDTH-1:0]     pipe_out_imag,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_real,
    output logic [WIDTH-1:0]     out_imag,
    output logic [2*LOG4N-1:0]   out_index,
    output logic                 out_last,
    output logic                 busy,
    output logic                 err
);
    localparam int LOG2N = 2 * LOG4N;
    localparam int PW = (MAX_INFLIGHT > 1) ?
                        $clog2(MAX_INFLIGHT) : 1;
    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    localparam logic [LOG2N-1:0] LAST  = LOG2N'(N - 1);
    localparam logic [LOG2N-1:0] C_ONE = LOG2N'(1);
    localparam logic [CW-1:0]    FULL  = CW'(MAX_INFLIGHT);
    localparam logic [CW-1:0]    T_ONE = CW'(1);
    localparam logic [PW-1:0]    PMAX  = PW'(MAX_INFLIGHT - 1);
    localparam logic [PW-1:0]    P_ONE = PW'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH
    } state_t;

    state_t                  state;
    logic [LOG2N-1:0]        in_cnt;
    logic [LOG2N-1:0]        out_cnt;
    logic [LOG2N-1:0]        rev_cnt;
    logic [MAX_INFLIGHT-1:0] tags;
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           tag_count;
    logic [CW-1:0]           real_count;
    logic                    run;
    logic                    accept;
    logic                    start_dummy;
    logic                    push;
    logic                    pop;
    logic                    head_real;
    logic                    fifo_empty;
    logic                    fifo_full;

    function automatic logic [PW-1:0] nxt(
        input logic [PW-1:0] p
    );
        return (p == PMAX) ? '0 : p + P_ONE;
    endfunction

    assign fifo_empty = (tag_count == '0);
    assign fifo_full  = (tag_count == FULL);
    assign head_real  = tags[rd_ptr];

    // Ready while loading, or idle with a free tag slot.
    always_comb begin
        src.in_ready = 1'b0;
        if (run) begin
            unique case (state)
                IDLE:    src.in_ready = !fifo_full;
                LOAD:    src.in_ready = 1'b1;
                default: src.in_ready = 1'b0;
            endcase
        end
    end

    assign accept = src.in_valid & src.in_ready;

    assign start_dummy = (state == IDLE) & flush &
                         !accept & !fifo_full &
                         (real_count != '0);

    assign push = (state == IDLE) & (accept | start_dummy);
    assign pop  = pipe_out_en & !fifo_empty &
                  (out_cnt == LAST);

    assign pipe_en   = accept | (state == FLUSH);
    assign pipe_real = accept ? src.in_real : '0;
    assign pipe_imag = accept ? src.in_imag : '0;

    assign busy = (state != IDLE) | !fifo_empty;

    // Base-4 digit reversal of the output position.
    always_comb begin
        rev_cnt = '0;
        for (int i = 0; i < LOG4N; i++) begin
            rev_cnt[2*i +: 2] = out_cnt[2*(LOG4N-1-i) +: 2];
        end
    end

    // Input sequencer: real frame loads and dummy flushes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            in_cnt <= '0;
            run    <= 1'b0;
        end else begin
            run <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        in_cnt <= C_ONE;
                        state  <= LOAD;
                    end else if (start_dummy) begin
                        in_cnt <= '0;
                        state  <= FLUSH;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (in_cnt == LAST) begin
                            in_cnt <= '0;
                            state  <= IDLE;
                        end else begin
                            in_cnt <= in_cnt + C_ONE;
                        end
                    end
                end
                FLUSH: begin
                    if (in_cnt == LAST) begin
                        in_cnt <= '0;
                        state  <= IDLE;
                    end else begin
                        in_cnt <= in_cnt + C_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag FIFO: one real/dummy bit per frame in the pipe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tags       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tag_count  <= '0;
            real_count <= '0;
        end else begin
            if (push) begin
                tags[wr_ptr] <= accept;
                wr_ptr       <= nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            if (push && !pop) begin
                tag_count <= tag_count + T_ONE;
            end else if (pop && !push) begin
                tag_count <= tag_count - T_ONE;
            end
            if ((push && accept) && !(pop && head_real)) begin
                real_count <= real_count + T_ONE;
            end else if (!(push && accept) && (pop && head_real)) begin
                real_count <= real_count - T_ONE;
            end
        end
    end

    // Output tagging: index, last flag, dummy suppression.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_cnt   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_real  <= '0;
            out_imag  <= '0;
            out_index <= '0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (pipe_out_en) begin
                if (fifo_empty) begin
                    err <= 1'b1;
                end else begin
                    out_cnt <= (out_cnt == LAST) ?
                               '0 : out_cnt + C_ONE;
                    if (head_real) begin
                        out_valid <= 1'b1;
                        out_real  <= pipe_out_real;
                        out_imag  <= pipe_out_imag;
                        out_index <= rev_cnt;
                        out_last  <= (out_cnt == LAST);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_fft_frame_controller.sv
// Bench for fft_frame_controller with a behavioural SDF
// stand-in (DFT per frame, digit-reversed, drained by next frame).
module tb_fft_frame_controller;
    localparam int N  = 16;
    localparam real PI = 3.14159265358979323846;

    localparam int K_IMP = 0;
    localparam int K_DC  = 1;
    localparam int K_ALT = 2;
    localparam int K_CPX = 3;

    localparam int IDX [N] = '{0, 4, 8, 12, 1, 5, 9, 13,
                               2, 6, 10, 14, 3, 7, 11, 15};

    logic        clock;
    logic        reset;
    logic        flush;
    logic        pipe_en;
    logic [31:0] pipe_real;
    logic [31:0] pipe_imag;
    logic        pipe_out_en;
    logic [31:0] pipe_out_real;
    logic [31:0] pipe_out_imag;
    logic        out_valid;
    logic [31:0] out_real;
    logic [31:0] out_imag;
    logic [3:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        err;
    logic        force_out;

    fft_frame_controller_if #(.WIDTH(32)) sif ();

    fft_frame_controller #(
        .WIDTH(32),
        .N(16),
        .LOG4N(2),
        .MAX_INFLIGHT(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .src(sif),
        .flush(flush),
        .pipe_en(pipe_en),
        .pipe_real(pipe_real),
        .pipe_imag(pipe_imag),
        .pipe_out_en(pipe_out_en),
        .pipe_out_real(pipe_out_real),
        .pipe_out_imag(pipe_out_imag),
        .out_valid(out_valid),
        .out_real(out_real),
        .out_imag(out_imag),
        .out_index(out_index),
        .out_last(out_last),
        .busy(busy),
        .err(err)
    );

    typedef struct {
        int re;
        int im;
        int idx;
        bit last;
    } exp_t;

    exp_t exp_q [$];
    exp_t e;

    int checks = 0;
    int errors = 0;
    int frames_done = 0;
    int pe_cnt = 0;
    int acc_total = 0;
    int first_refuse = -1;
    int frames_at_rise = -1;
    bit rise_seen = 0;
    bit track = 0;

    int cur_re [$];
    int cur_im [$];
    int q_re [$];
    int q_im [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    function automatic int dft(input int b, input bit im_part);
        real acc;
        real a;
        acc = 0.0;
        for (int n = 0; n < N; n++) begin
            a = -2.0 * PI * b * n / N;
            if (im_part)
                acc += cur_re[n] * $sin(a) + cur_im[n] * $cos(a);
            else
                acc += cur_re[n] * $cos(a) - cur_im[n] * $sin(a);
        end
        return rnd(acc);
    endfunction

    // Pipeline stand-in: each input sample releases one result
    // of the previously completed frame, one cycle later.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_re.delete();
            cur_im.delete();
            q_re.delete();
            q_im.delete();
            pipe_out_en   <= 1'b0;
            pipe_out_real <= '0;
            pipe_out_imag <= '0;
        end else begin
            pipe_out_en <= 1'b0;
            if (force_out) begin
                pipe_out_en   <= 1'b1;
                pipe_out_real <= 32'd1234;
                pipe_out_imag <= 32'd0;
            end
            if (pipe_en) begin
                if (q_re.size() > 0) begin
                    pipe_out_en   <= 1'b1;
                    pipe_out_real <= q_re.pop_front();
                    pipe_out_imag <= q_im.pop_front();
                end
                cur_re.push_back($signed(pipe_real));
                cur_im.push_back($signed(pipe_imag));
                if (cur_re.size() == N) begin
                    for (int k = 0; k < N; k++) begin
                        q_re.push_back(dft((k % 4) * 4 + k / 4, 1'b0));
                        q_im.push_back(dft((k % 4) * 4 + k / 4, 1'b1));
                    end
                    cur_re.delete();
                    cur_im.delete();
                end
            end
        end
    end

    always @(posedge clock) begin
        if (pipe_en) pe_cnt <= pe_cnt + 1;
    end

    function automatic bit near(input int a, input int b);
        return (a - b <= 1) && (b - a <= 1);
    endfunction

    // Scoreboard monitor.
    always @(negedge clock) begin
        if (reset && out_last && !out_valid) begin
            checks++;
            errors++;
            $display("FAIL last_without_valid: out_last=1 out_valid=0");
        end
        if (reset && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: idx=%0d re=%0d, required no output",
                         out_index, $signed(out_real));
            end else begin
                e = exp_q.pop_front();
                if (!near($signed(out_real), e.re) ||
                    !near($signed(out_imag), e.im) ||
                    (int'(out_index) != e.idx) ||
                    (out_last != e.last)) begin
                    errors++;
                    $display("FAIL result: got re=%0d im=%0d idx=%0d last=%0b, required re=%0d im=%0d idx=%0d last=%0b",
                             $signed(out_real), $signed(out_imag),
                             out_index, out_last,
                             e.re, e.im, e.idx, e.last);
                end
                if (out_last) frames_done++;
            end
        end
    end

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic sample(input int kind, input int n,
                          output int re, output int im);
        re = 0;
        im = 0;
        case (kind)
            K_IMP: re = (n == 0) ? 1000 : 0;
            K_DC:  re = 1000;
            K_ALT: re = (n % 2 == 1) ? -1000 : 1000;
            K_CPX: begin re = -500; im = 250; end
            default: re = 0;
        endcase
    endtask

    task automatic push_expect(input int kind);
        exp_t x;
        for (int k = 0; k < N; k++) begin
            x.idx  = IDX[k];
            x.last = (k == N - 1);
            x.re   = 0;
            x.im   = 0;
            case (kind)
                K_IMP: x.re = 1000;
                K_DC:  if (x.idx == 0) x.re = 16000;
                K_ALT: if (x.idx == 8) x.re = 16000;
                K_CPX: if (x.idx == 0) begin x.re = -8000; x.im = 4000; end
                default: x.re = 0;
            endcase
            exp_q.push_back(x);
        end
    endtask

    task automatic wait_ready();
        int t;
        bit waited;
        t = 0;
        waited = 0;
        while (!sif.in_ready && t < 100) begin
            if (track && first_refuse < 0) first_refuse = acc_total;
            waited = 1;
            @(negedge clock);
            t++;
        end
        if (!sif.in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: in_ready=0 for %0d cycles, required 1", t);
        end else if (waited && track && !rise_seen) begin
            #1;
            frames_at_rise = frames_done;
            rise_seen = 1;
        end
    endtask

    task automatic send_frame(input int kind, input bit gap,
                              input int nsamp, input bit expect_out);
        int re;
        int im;
        if (expect_out) push_expect(kind);
        for (int n = 0; n < nsamp; n++) begin
            sample(kind, n, re, im);
            sif.in_valid = 1'b1;
            sif.in_real  = re;
            sif.in_imag  = im;
            wait_ready();
            @(negedge clock);
            acc_total++;
            if (gap) begin
                sif.in_valid = 1'b0;
                @(negedge clock);
            end
        end
        sif.in_valid = 1'b0;
        sif.in_real  = '0;
        sif.in_imag  = '0;
    endtask

    task automatic do_flush();
        int t;
        t = 0;
        flush = 1'b1;
        @(negedge clock);
        while (!pipe_en && t < 100) begin
            @(negedge clock);
            t++;
        end
        checks++;
        if (!pipe_en) begin
            errors++;
            $display("FAIL flush_start: pipe_en=0 after %0d cycles, required 1", t);
        end
        flush = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clock);
            t++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, required 0",
                     exp_q.size());
            exp_q.delete();
        end
        repeat (5) @(negedge clock);
    endtask

    initial begin
        int pe0;
        int nbusy;
        int fdone0;
        reset        = 1'b0;
        flush        = 1'b0;
        force_out    = 1'b0;
        sif.in_valid = 1'b0;
        sif.in_real  = '0;
        sif.in_imag  = '0;
        repeat (3) @(negedge clock);
        chk("rst_in_ready", sif.in_ready, 0);
        chk("rst_pipe_en", pipe_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("ready_after_reset", sif.in_ready, 1);

        pe0 = pe_cnt;
        nbusy = 0;
        flush = 1'b1;
        repeat (8) begin
            @(negedge clock);
            if (busy) nbusy++;
        end
        flush = 1'b0;
        chk("idle_flush_pipe_en", pe_cnt - pe0, 0);
        chk("idle_flush_busy", nbusy, 0);

        send_frame(K_IMP, 1'b0, N, 1'b1);
        do_flush();
        drain();

        send_frame(K_DC, 1'b0, N, 1'b1);
        do_flush();
        drain();
        chk("err_after_dc", err, 0);

        send_frame(K_ALT, 1'b0, 7, 1'b0);
        reset = 1'b0;
        #1;
        chk("abort_in_ready", sif.in_ready, 0);
        chk("abort_pipe_en", pipe_en, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_real", out_real, 0);
        chk("abort_out_index", out_index, 0);
        chk("abort_busy", busy, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("ready_after_abort", sif.in_ready, 1);

        force_out = 1'b1;
        @(negedge clock);
        force_out = 1'b0;
        @(negedge clock);
        chk("err_set", err, 1);
        chk("err_out_valid", out_valid, 0);
        chk("err_busy", busy, 0);

        acc_total = 0;
        first_refuse = -1;
        rise_seen = 0;
        fdone0 = frames_done;
        track = 1;
        send_frame(K_ALT, 1'b0, N, 1'b1);
        send_frame(K_CPX, 1'b0, N, 1'b1);
        send_frame(K_IMP, 1'b0, N, 1'b1);
        track = 0;
        chk("refuse_at_accept", first_refuse, 32);
        chk("rise_after_pop", frames_at_rise - fdone0, 1);
        do_flush();
        drain();

        pe0 = pe_cnt;
        send_frame(K_DC, 1'b1, N, 1'b1);
        chk("gap_pipe_en_pulses", pe_cnt - pe0, N);
        do_flush();
        drain();

        chk("err_sticky", err, 1);
        reset = 1'b0;
        #1;
        chk("err_cleared", err, 0);
        reset = 1'b1;
        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
